kavach_threat_response_ctrl: RTL and testbench
==============================================

Name: kavach_threat_response_ctrl

Overview:
- Sits directly downstream of the execution monitor. Consumes its per-class anomaly flags, severity, last anomalous PC and ready signal.
- Runs an escalation state machine that drives the CPU interrupt, the pipeline halt and the key-zeroize pulse.
- Keeps a small first-word-fall-through event log that software drains over a pop handshake.

Parameters:
- PC_WIDTH, 32, width of logged PC
- LOG_DEPTH, 8, event log entries (power of two)
- TS_WIDTH, 16, free-running timestamp width
- ALERT_PERSIST, 16, consecutive severity-2 cycles in ALERT before CONTAIN
- LOCK_PERSIST, 8, consecutive severity-3 cycles in CONTAIN before LOCKDOWN
- LOCK_STRIKES, 3, CONTAIN entries before LOCKDOWN
- QUIET_CYCLES, 64, consecutive severity-0 cycles in ALERT before auto-return to IDLE
- RECOVER_CYCLES, 32, clean cycles in RECOVER before IDLE
- UNLOCK_EN, 1, 1 = sw_clear_lock may exit LOCKDOWN; 0 = LOCKDOWN exits only on reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- monitor_ready  in  1  upstream warmed up; all inputs ignored while 0
- severity  in  2  upstream severity 0..3
- anomaly_vec  in  6  {nmi, flush, mem_oob, priv, pc_jump, ipc}
- last_bad_pc  in  PC_WIDTH  upstream last anomalous PC
- sw_ack  in  1  software acknowledge (single-cycle pulse)
- sw_clear_lock  in  1  software unlock request
- log_pop  in  1  consume head log entry
- threat_state  out  3  0 IDLE, 1 ALERT, 2 CONTAIN, 3 LOCKDOWN, 4 RECOVER
- irq  out  1  interrupt to CPU
- cpu_halt  out  1  pipeline halt request
- key_zeroize  out  1  one-cycle pulse on LOCKDOWN entry
- strike_cnt  out  2  saturating CONTAIN-entry count
- log_valid  out  1  log not empty
- log_pc  out  PC_WIDTH  head entry PC
- log_vec  out  6  head entry anomaly vector
- log_sev  out  2  head entry severity
- log_ts  out  TS_WIDTH  head entry timestamp
- log_count  out  log2(LOG_DEPTH)+1  occupancy
- log_overflow  out  1  sticky; an entry was dropped

Behaviour:
- Reset:
  - All outputs 0; state IDLE; all counters, timestamp and log pointers 0.
  - Reset mid-operation aborts any state, including LOCKDOWN, and empties the log.
- Qualified severity: sev_q = monitor_ready ? severity : 0. All FSM decisions use sev_q sampled in the current cycle; the state register updates on the next edge.
- Outputs are registered Moore outputs of the next state, so they change on the same edge as threat_state:
  - irq = 1 in ALERT, CONTAIN, LOCKDOWN.
  - cpu_halt = 1 in CONTAIN, LOCKDOWN.
- IDLE:
  - sev_q=3 → CONTAIN.
  - sev_q=1 or 2 → ALERT.
- ALERT:
  - sev_q=3 → CONTAIN.
  - persist_cnt counts consecutive sev_q=2 cycles, reset on any other value; reaching ALERT_PERSIST → CONTAIN.
  - sw_ack with sev_q=0 → IDLE.
  - quiet_cnt counts consecutive sev_q=0 cycles; reaching QUIET_CYCLES → IDLE.
- CONTAIN entry: strike_cnt increments, saturating at 3.
  - If the incremented value ≥ LOCK_STRIKES, the FSM goes to LOCKDOWN on the next edge instead of staying in CONTAIN.
- CONTAIN:
  - Consecutive sev_q=3 count reaching LOCK_PERSIST → LOCKDOWN.
  - sw_ack with sev_q=0 → RECOVER.
  - sw_ack with sev_q≠0 is ignored.
- LOCKDOWN:
  - key_zeroize is high exactly in the first LOCKDOWN cycle.
  - Exit only on sw_clear_lock && sev_q=0 && UNLOCK_EN=1 → RECOVER; this also clears strike_cnt.
- RECOVER:
  - rec_cnt counts cycles.
  - Any sev_q≠0 → CONTAIN (strike rule applies).
  - rec_cnt reaching RECOVER_CYCLES → IDLE.
- Each state's counters clear on state entry.
- Log push:
  - Condition: monitor_ready && (anomaly_vec & ~vec_d) ≠ 0, where vec_d is anomaly_vec registered one cycle.
  - Entry = {timestamp, severity, anomaly_vec, last_bad_pc}, all sampled that cycle.
  - Timestamp increments every cycle and wraps.
- Log pop:
  - log_pop && log_valid advances the head.
  - Head fields are valid whenever log_valid=1.
  - Pop when empty is ignored.
- Full log:
  - A push is dropped and log_overflow is set.
  - Push and pop in the same cycle when full: both are accepted, no overflow.
  - Push and pop in the same cycle when empty: the entry is stored; the pop is ignored.
- log_overflow clears on sw_ack. If a drop occurs in the same cycle as sw_ack, the set wins.

Test Plan:
- monitor_ready=0, severity=3 for 100 cycles → threat_state stays 0; no log push.
- severity=2 for 16 cycles → ALERT on cycle 1, CONTAIN after 16 consecutive; cpu_halt=1; strike_cnt=1.
- CONTAIN, then severity=0 + sw_ack → RECOVER, cpu_halt=0; 32 clean cycles → IDLE, irq=0.
- Three severity-3 bursts, each acked and followed by re-trigger in RECOVER → third CONTAIN entry goes to LOCKDOWN; key_zeroize high for exactly 1 cycle; sw_ack ignored; sw_clear_lock with sev 0 → RECOVER, strike_cnt=0.
- Ten distinct rising anomaly_vec edges with no pops → log_count=8, log_overflow=1; eight pops return the first 8 PCs in order with increasing log_ts; log_valid=0 afterwards.
- Log full with push and pop in the same cycle → log_count stays 8, log_overflow unchanged; assert rst_n low in LOCKDOWN → all outputs 0, log empty.

Source files
------------

// File: rtl/kavach_threat_response_ctrl.sv
// Threat escalation controller: drives irq / cpu_halt / key_zeroize from the
// execution monitor's severity stream and keeps a small FWFT event log.
module kavach_threat_response_ctrl #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned LOG_DEPTH      = 8,
  parameter int unsigned TS_WIDTH       = 16,
  parameter int unsigned ALERT_PERSIST  = 16,
  parameter int unsigned LOCK_PERSIST   = 8,
  parameter int unsigned LOCK_STRIKES   = 3,
  parameter int unsigned QUIET_CYCLES   = 64,
  parameter int unsigned RECOVER_CYCLES = 32,
  parameter bit          UNLOCK_EN      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        monitor_ready,
  input  logic [1:0]                  severity,
  input  logic [5:0]                  anomaly_vec,
  input  logic [PC_WIDTH-1:0]         last_bad_pc,
  input  logic                        sw_ack,
  input  logic                        sw_clear_lock,
  input  logic                        log_pop,
  output logic [2:0]                  threat_state,
  output logic                        irq,
  output logic                        cpu_halt,
  output logic                        key_zeroize,
  output logic [1:0]                  strike_cnt,
  output logic                        log_valid,
  output logic [PC_WIDTH-1:0]         log_pc,
  output logic [5:0]                  log_vec,
  output logic [1:0]                  log_sev,
  output logic [TS_WIDTH-1:0]         log_ts,
  output logic [$clog2(LOG_DEPTH):0]  log_count,
  output logic                        log_overflow
);

  localparam int unsigned AW    = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = $clog2(ALERT_PERSIST + QUIET_CYCLES + LOCK_PERSIST + RECOVER_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALERT    = 3'd1,
    ST_CONTAIN  = 3'd2,
    ST_LOCKDOWN = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [1:0]          sev;
    logic [5:0]          vec;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  state_t              state_r, next_state_s;
  logic [1:0]          sev_q_s;
  logic [CNT_W-1:0]    persist_cnt_r, quiet_cnt_r, lock_cnt_r, rec_cnt_r;
  logic                irq_r, halt_r, zeroize_r;
  logic [1:0]          strike_r;

  entry_t              log_mem_r [LOG_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [AW:0]         count_r;
  logic                overflow_r;
  logic [5:0]          vec_d_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic                push_s, pop_s, full_s, accept_s, drop_s;

  assign sev_q_s = monitor_ready ? severity : 2'd0;

  // Escalation next-state decision from the qualified severity.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sev_q_s == 2'd3)      next_state_s = ST_CONTAIN;
        else if (sev_q_s != 2'd0) next_state_s = ST_ALERT;
        else                      next_state_s = ST_IDLE;
      end
      ST_ALERT: begin
        if (sev_q_s == 2'd3)
          next_state_s = ST_CONTAIN;
        else if (sev_q_s == 2'd2 && persist_cnt_r == CNT_W'(ALERT_PERSIST - 32'd1))
          next_state_s = ST_CONTAIN;
        else if (sev_q_s == 2'd0 && (sw_ack || quiet_cnt_r == CNT_W'(QUIET_CYCLES - 32'd1)))
          next_state_s = ST_IDLE;
        else
          next_state_s = ST_ALERT;
      end
      ST_CONTAIN: begin
        // A strike count already at the limit forces lockdown one cycle after entry.
        if ({30'd0, strike_r} >= LOCK_STRIKES)
          next_state_s = ST_LOCKDOWN;
        else if (sev_q_s == 2'd3 && lock_cnt_r == CNT_W'(LOCK_PERSIST - 32'd1))
          next_state_s = ST_LOCKDOWN;
        else if (sw_ack && sev_q_s == 2'd0)
          next_state_s = ST_RECOVER;
        else
          next_state_s = ST_CONTAIN;
      end
      ST_LOCKDOWN: begin
        if (UNLOCK_EN && sw_clear_lock && sev_q_s == 2'd0) next_state_s = ST_RECOVER;
        else                                               next_state_s = ST_LOCKDOWN;
      end
      ST_RECOVER: begin
        if (sev_q_s != 2'd0)                                       next_state_s = ST_CONTAIN;
        else if (rec_cnt_r == CNT_W'(RECOVER_CYCLES - 32'd1))      next_state_s = ST_IDLE;
        else                                                       next_state_s = ST_RECOVER;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, per-state counters, strike count and Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      persist_cnt_r <= '0;
      quiet_cnt_r   <= '0;
      lock_cnt_r    <= '0;
      rec_cnt_r     <= '0;
      strike_r      <= 2'd0;
      irq_r         <= 1'b0;
      halt_r        <= 1'b0;
      zeroize_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      irq_r     <= (next_state_s == ST_ALERT) || (next_state_s == ST_CONTAIN) || (next_state_s == ST_LOCKDOWN);
      halt_r    <= (next_state_s == ST_CONTAIN) || (next_state_s == ST_LOCKDOWN);
      zeroize_r <= (next_state_s == ST_LOCKDOWN) && (state_r != ST_LOCKDOWN);
      if (next_state_s != state_r) begin
        persist_cnt_r <= '0;
        quiet_cnt_r   <= '0;
        lock_cnt_r    <= '0;
        rec_cnt_r     <= '0;
      end else begin
        persist_cnt_r <= (state_r == ST_ALERT && sev_q_s == 2'd2) ? persist_cnt_r + CNT_W'(1) : '0;
        quiet_cnt_r   <= (state_r == ST_ALERT && sev_q_s == 2'd0) ? quiet_cnt_r + CNT_W'(1) : '0;
        lock_cnt_r    <= (state_r == ST_CONTAIN && sev_q_s == 2'd3) ? lock_cnt_r + CNT_W'(1) : '0;
        rec_cnt_r     <= (state_r == ST_RECOVER) ? rec_cnt_r + CNT_W'(1) : '0;
      end
      if (state_r == ST_LOCKDOWN && next_state_s == ST_RECOVER)
        strike_r <= 2'd0;
      else if (next_state_s == ST_CONTAIN && state_r != ST_CONTAIN && strike_r != 2'd3)
        strike_r <= strike_r + 2'd1;
      else
        strike_r <= strike_r;
    end
  end

  assign threat_state = state_r;
  assign irq          = irq_r;
  assign cpu_halt     = halt_r;
  assign key_zeroize  = zeroize_r;
  assign strike_cnt   = strike_r;

  assign push_s   = monitor_ready && ((anomaly_vec & ~vec_d_r) != 6'd0);
  assign pop_s    = log_pop && (count_r != '0);
  assign full_s   = (count_r == (AW+1)'(LOG_DEPTH));
  // When full, a simultaneous pop frees the slot the push needs.
  assign accept_s = push_s && (!full_s || pop_s);
  assign drop_s   = push_s && !accept_s;

  // Event log storage, pointers, occupancy, overflow flag and timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG_DEPTH; i++) log_mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      vec_d_r    <= 6'd0;
      ts_r       <= '0;
    end else begin
      vec_d_r <= anomaly_vec;
      ts_r    <= ts_r + TS_WIDTH'(1);
      if (accept_s) begin
        log_mem_r[wr_ptr_r] <= '{ts: ts_r, sev: severity, vec: anomaly_vec, pc: last_bad_pc};
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s)      overflow_r <= 1'b1;
      else if (sw_ack) overflow_r <= 1'b0;
      else             overflow_r <= overflow_r;
    end
  end

  assign log_valid    = (count_r != '0);
  assign log_count    = count_r;
  assign log_overflow = overflow_r;
  assign log_pc       = log_mem_r[rd_ptr_r].pc;
  assign log_vec      = log_mem_r[rd_ptr_r].vec;
  assign log_sev      = log_mem_r[rd_ptr_r].sev;
  assign log_ts       = log_mem_r[rd_ptr_r].ts;

endmodule

// File: tb/tb_kavach_threat_response_ctrl.sv
// Directed self-checking bench for kavach_threat_response_ctrl (default parameters).
module tb_kavach_threat_response_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        monitor_ready;
  logic [1:0]  severity;
  logic [5:0]  anomaly_vec;
  logic [31:0] last_bad_pc;
  logic        sw_ack, sw_clear_lock, log_pop;
  logic [2:0]  threat_state;
  logic        irq, cpu_halt, key_zeroize;
  logic [1:0]  strike_cnt;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [5:0]  log_vec;
  logic [1:0]  log_sev;
  logic [15:0] log_ts;
  logic [3:0]  log_count;
  logic        log_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  kavach_threat_response_ctrl dut (
    .clk(clk), .rst_n(rst_n), .monitor_ready(monitor_ready), .severity(severity),
    .anomaly_vec(anomaly_vec), .last_bad_pc(last_bad_pc), .sw_ack(sw_ack),
    .sw_clear_lock(sw_clear_lock), .log_pop(log_pop), .threat_state(threat_state),
    .irq(irq), .cpu_halt(cpu_halt), .key_zeroize(key_zeroize), .strike_cnt(strike_cnt),
    .log_valid(log_valid), .log_pc(log_pc), .log_vec(log_vec), .log_sev(log_sev),
    .log_ts(log_ts), .log_count(log_count), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [5:0] v, input logic [31:0] pc, input logic pop);
    anomaly_vec = v;
    last_bad_pc = pc;
    log_pop     = pop;
    step(1);
    anomaly_vec = 6'd0;
    log_pop     = 1'b0;
    step(1);
  endtask

  logic [31:0] exp_pc [10];
  logic [5:0]  exp_vec [10];
  logic [15:0] prev_ts;
  logic [15:0] ts_delta;

  initial begin
    rst_n = 1'b0; monitor_ready = 1'b0; severity = 2'd0; anomaly_vec = 6'd0;
    last_bad_pc = 32'd0; sw_ack = 1'b0; sw_clear_lock = 1'b0; log_pop = 1'b0;
    step(2);
    check_eq("rst_state", threat_state, 3'd0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_halt", cpu_halt, 1'b0);
    check_eq("rst_zeroize", key_zeroize, 1'b0);
    check_eq("rst_count", log_count, 4'd0);
    check_eq("rst_pc", log_pc, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Monitor not ready: severity and anomalies ignored.
    severity = 2'd3; anomaly_vec = 6'h3F; last_bad_pc = 32'hDEAD_0000;
    step(100);
    check_eq("nrdy_state", threat_state, 3'd0);
    check_eq("nrdy_irq", irq, 1'b0);
    check_eq("nrdy_log", log_count, 4'd0);
    severity = 2'd0; anomaly_vec = 6'd0; monitor_ready = 1'b1;
    step(1);

    // Persistent severity 2 escalates ALERT -> CONTAIN after 16 ALERT cycles.
    severity = 2'd2;
    step(1);
    check_eq("alert_state", threat_state, 3'd1);
    check_eq("alert_irq", irq, 1'b1);
    step(15);
    check_eq("alert_hold", threat_state, 3'd1);
    check_eq("alert_nohalt", cpu_halt, 1'b0);
    step(1);
    check_eq("contain_state", threat_state, 3'd2);
    check_eq("contain_halt", cpu_halt, 1'b1);
    check_eq("strike_1", strike_cnt, 2'd1);

    // Ack with nonzero severity ignored, ack with severity 0 -> RECOVER -> IDLE.
    severity = 2'd1; sw_ack = 1'b1;
    step(1);
    check_eq("ack_ignored", threat_state, 3'd2);
    severity = 2'd0;
    step(1);
    sw_ack = 1'b0;
    check_eq("recover_state", threat_state, 3'd4);
    check_eq("recover_halt", cpu_halt, 1'b0);
    step(31);
    check_eq("recover_hold", threat_state, 3'd4);
    step(1);
    check_eq("idle_after_rec", threat_state, 3'd0);
    check_eq("idle_irq", irq, 1'b0);

    // Further CONTAIN entries until the third strike forces LOCKDOWN.
    severity = 2'd3;
    step(1);
    check_eq("strike_2", strike_cnt, 2'd2);
    severity = 2'd0; sw_ack = 1'b1;
    step(1);
    sw_ack = 1'b0;
    check_eq("rec_again", threat_state, 3'd4);
    severity = 2'd3;
    step(1);
    check_eq("contain_3", threat_state, 3'd2);
    check_eq("strike_3", strike_cnt, 2'd3);
    severity = 2'd0;
    step(1);
    check_eq("lockdown_state", threat_state, 3'd3);
    check_eq("zeroize_pulse", key_zeroize, 1'b1);
    check_eq("lock_halt", cpu_halt, 1'b1);
    step(1);
    check_eq("zeroize_one", key_zeroize, 1'b0);
    sw_ack = 1'b1;
    step(1);
    sw_ack = 1'b0;
    check_eq("lock_ack_ign", threat_state, 3'd3);
    sw_clear_lock = 1'b1; severity = 2'd1;
    step(1);
    check_eq("unlock_sev_ign", threat_state, 3'd3);
    severity = 2'd0;
    step(1);
    sw_clear_lock = 1'b0;
    check_eq("unlock_state", threat_state, 3'd4);
    check_eq("unlock_strike", strike_cnt, 2'd0);
    step(32);
    check_eq("unlock_idle", threat_state, 3'd0);

    // ALERT exits: ack with sev 0, and 64 quiet cycles.
    severity = 2'd1;
    step(1);
    severity = 2'd0; sw_ack = 1'b1;
    step(1);
    sw_ack = 1'b0;
    check_eq("alert_ack_idle", threat_state, 3'd0);
    severity = 2'd1;
    step(1);
    severity = 2'd0;
    step(63);
    check_eq("quiet_hold", threat_state, 3'd1);
    step(1);
    check_eq("quiet_idle", threat_state, 3'd0);

    // Ten rising edges without pops: 8 stored, overflow set.
    for (int i = 0; i < 10; i++) begin
      exp_pc[i]  = 32'hA000_0000 + 32'(i);
      exp_vec[i] = 6'd1 << (i % 6);
      severity   = (i == 0) ? 2'd1 : 2'd0;
      push_entry(exp_vec[i], exp_pc[i], 1'b0);
    end
    severity = 2'd0;
    check_eq("fill_count", log_count, 4'd8);
    check_eq("fill_ovf", log_overflow, 1'b1);
    check_eq("fill_sev0", log_sev, 2'd1);
    prev_ts = 16'd0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("pop_pc%0d", k), log_pc, exp_pc[k]);
      check_eq($sformatf("pop_vec%0d", k), log_vec, exp_vec[k]);
      if (k > 0) begin
        ts_delta = log_ts - prev_ts;
        check_eq($sformatf("pop_ts%0d", k), ts_delta, 16'd2);
      end
      prev_ts = log_ts;
      log_pop = 1'b1;
      step(1);
      log_pop = 1'b0;
    end
    check_eq("drain_valid", log_valid, 1'b0);
    check_eq("drain_count", log_count, 4'd0);
    log_pop = 1'b1;
    step(1);
    log_pop = 1'b0;
    check_eq("empty_pop", log_count, 4'd0);
    check_eq("ovf_sticky", log_overflow, 1'b1);
    sw_ack = 1'b1;
    step(1);
    sw_ack = 1'b0;
    check_eq("ovf_clear", log_overflow, 1'b0);

    // Push with pop on empty stores; push with pop on full keeps 8, no overflow.
    push_entry(6'h04, 32'hB000_0000, 1'b1);
    check_eq("empty_pp_count", log_count, 4'd1);
    check_eq("empty_pp_pc", log_pc, 32'hB000_0000);
    for (int j = 1; j < 8; j++) push_entry(6'h08, 32'hB000_0000 + 32'(j), 1'b0);
    check_eq("refill_count", log_count, 4'd8);
    push_entry(6'h10, 32'hC000_0000, 1'b1);
    check_eq("full_pp_count", log_count, 4'd8);
    check_eq("full_pp_ovf", log_overflow, 1'b0);
    check_eq("full_pp_head", log_pc, 32'hB000_0001);
    anomaly_vec = 6'h20; sw_ack = 1'b1;
    step(1);
    anomaly_vec = 6'd0; sw_ack = 1'b0;
    check_eq("drop_ack_set", log_overflow, 1'b1);

    // Reach LOCKDOWN via persistent severity 3, then reset asynchronously.
    severity = 2'd3;
    step(1);
    check_eq("persist_contain", threat_state, 3'd2);
    step(8);
    check_eq("persist_lock", threat_state, 3'd3);
    check_eq("persist_zeroize", key_zeroize, 1'b1);
    rst_n = 1'b0;
    #2;
    check_eq("arst_state", threat_state, 3'd0);
    check_eq("arst_irq", irq, 1'b0);
    check_eq("arst_halt", cpu_halt, 1'b0);
    check_eq("arst_zeroize", key_zeroize, 1'b0);
    check_eq("arst_strike", strike_cnt, 2'd0);
    check_eq("arst_valid", log_valid, 1'b0);
    check_eq("arst_count", log_count, 4'd0);
    check_eq("arst_ovf", log_overflow, 1'b0);
    severity = 2'd0;
    step(1);
    rst_n = 1'b1;
    step(2);
    check_eq("post_rst_state", threat_state, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
